// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Multiply is a 32-step shift-add into a 64-bit product.
//   Divide is a 32-step restoring divider that yields a quotient and a remainder.
//   Both run on operand magnitudes. The sign is applied in a single FIX cycle.
//   Divide-by-zero and signed overflow skip straight to DONE one cycle after start.
//
// Ports
//   clock          single clock, rising edge
//   reset          synchronous, active-high
//   start          begin an operation (sampled only in IDLE)
//   funct3[2:0]    0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op_a, op_b     dividend/multiplicand, divisor/multiplier
//   rd_in[4:0]     destination register, captured with the operands
//   busy           high in every state except IDLE
//   done           one-cycle pulse: result/rd_out valid (register-file write enable)
//   result, rd_out outcome and destination, held until the next DONE
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 shift-add / restoring-divide iterations
// FIX   | sign correction and output word select
// DONE  | result valid, done pulse, back to IDLE next edge

module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            neg_q;
   logic [CW-1:0]   cnt;
   // hi/lo: product upper/lower for multiply, remainder/quotient for divide
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   // multiplicand magnitude for multiply, divisor magnitude for divide
   logic [XLEN-1:0] addend;

   logic            a_signed, b_signed, neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf, quick;
   logic [XLEN-1:0] quick_result;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_word;

   // Operand decode for the start edge
   always_comb begin
      a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
      b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
      neg_a    = a_signed & op_a[XLEN-1];
      neg_b    = b_signed & op_b[XLEN-1];
      // The magnitude of the most negative value is exactly 2^31 when read as unsigned.
      mag_a    = neg_a ? -op_a : op_a;
      mag_b    = neg_b ? -op_b : op_b;
      div_zero = funct3[2] && (op_b == '0);
      div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      quick    = div_zero | div_ovf;
      if (div_zero)
         quick_result = funct3[1] ? op_a : '1;
      else
         quick_result = funct3[1] ? '0 : op_a;
   end

   // One iteration step and the sign-fix word
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, addend} : {(XLEN+1){1'b0}});
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, addend};
      prod_fix  = neg_q ? -{hi, lo} : {hi, lo};
      quo_fix   = neg_q ? -lo : lo;
      rem_fix   = neg_q ? -hi : hi;
      case (f3_q)
         3'd0:                   fix_word = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:       fix_word = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:             fix_word = quo_fix;
         default:                fix_word = rem_fix;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = quick ? DONE : CALC;
         CALC: if (cnt == '1) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         f3_q   <= '0;
         rd_q   <= '0;
         neg_q  <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         addend <= '0;
         result <= '0;
         rd_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  f3_q <= funct3;
                  rd_q <= rd_in;
                  cnt  <= '0;
                  hi   <= '0;
                  // Remainders take the dividend's sign. Everything else takes the XOR of both signs.
                  neg_q <= (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b);
                  if (funct3[2]) begin
                     lo     <= mag_a;
                     addend <= mag_b;
                  end else begin
                     lo     <= mag_b;
                     addend <= mag_a;
                  end
                  if (quick) begin
                     result <= quick_result;
                     rd_out <= rd_in;
                  end
               end
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (f3_q[2]) begin
                  // A borrow out of the 33-bit subtract means the trial remainder was below the divisor.
                  if (!div_diff[XLEN]) begin
                     hi <= div_diff[XLEN-1:0];
                     lo <= {lo[XLEN-2:0], 1'b1};
                  end else begin
                     hi <= div_shift[XLEN-1:0];
                     lo <= {lo[XLEN-2:0], 1'b0};
                  end
               end else begin
                  hi <= mul_sum[XLEN:1];
                  lo <= {mul_sum[0], lo[XLEN-1:1]};
               end
            end
            FIX: begin
               result <= fix_word;
               rd_out <= rd_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner vectors, randomized
// operations against an arithmetic reference model, start-while-busy and
// mid-operation reset scenarios.

module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   muldiv_unit #(.XLEN(32)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = '0;
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
         3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
         default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 34;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Drives one operation.
   // lat: cycles from the start edge until done is seen (0 means timeout).
   // bcnt: busy cycles over that span.
   // post_*: values sampled one cycle after done.
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int bcnt,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output logic post_done, output logic post_busy,
                        output logic [31:0] post_res);
      funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
      @(posedge clock); #1;
      start  = 1'b0;
      funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
      lat = 0; bcnt = 0;
      for (int i = 1; i <= 60; i++) begin
         if (busy) bcnt++;
         if (done) begin lat = i; break; end
         @(posedge clock); #1;
      end
      res = result; rdo = rd_out;
      @(posedge clock); #1;
      post_done = done; post_busy = busy; post_res = result;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd3; rd_in = 5'd4;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b expected 0", done); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", result); end
      checks++; if (rd_out !== 5'h0) begin errors++; $display("FAIL reset_rd_out got %h expected 00", rd_out); end
      reset = 1'b0; start = 1'b0;
      @(posedge clock); #1;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_no_start got busy %b expected 0", busy); end
   endtask

   logic [2:0]  v_f   [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
   logic [31:0] v_a   [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
   logic [31:0] v_b   [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
   logic [31:0] v_exp [14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h1,
                               32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000, 32'h0, 32'hFFFF_FFFF};
   int          v_lat [14] = '{34, 34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1};

   task automatic test_directed();
      int lat, bcnt;
      logic [31:0] res, pres;
      logic [4:0] rdo, rd;
      logic pd, pb;
      for (int i = 0; i < 14; i++) begin
         rd = 5'(i + 3);
         do_op(v_f[i], v_a[i], v_b[i], rd, lat, bcnt, res, rdo, pd, pb, pres);
         checks++; if (res !== v_exp[i]) begin errors++; $display("FAIL dir%0d_result got %h expected %h", i, res, v_exp[i]); end
         checks++; if (lat !== v_lat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d expected %0d", i, lat, v_lat[i]); end
         checks++; if (bcnt !== v_lat[i]) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d expected %0d", i, bcnt, v_lat[i]); end
         checks++; if (rdo !== rd) begin errors++; $display("FAIL dir%0d_rd_out got %0d expected %0d", i, rdo, rd); end
         checks++; if (pd !== 1'b0 || pb !== 1'b0) begin errors++; $display("FAIL dir%0d_after_done got done %b busy %b expected 0 0", i, pd, pb); end
         checks++; if (pres !== v_exp[i]) begin errors++; $display("FAIL dir%0d_result_hold got %h expected %h", i, pres, v_exp[i]); end
      end
   endtask

   task automatic test_random();
      int lat, bcnt, elat;
      logic [31:0] a, b, res, pres, exp;
      logic [2:0] f;
      logic [4:0] rdo, rd;
      logic pd, pb;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7)); a = pick(); b = pick(); rd = 5'($urandom);
         exp  = model(f, a, b);
         elat = model_lat(f, a, b);
         do_op(f, a, b, rd, lat, bcnt, res, rdo, pd, pb, pres);
         checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result f%0d a=%h b=%h got %h expected %h", i, f, a, b, res, exp); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency got %0d expected %0d", i, lat, elat); end
         checks++; if (rdo !== rd) begin errors++; $display("FAIL rnd%0d_rd_out got %0d expected %0d", i, rdo, rd); end
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      logic [31:0] exp;
      exp = model(3'd0, 32'h0001_2345, 32'h0000_0100);
      funct3 = 3'd0; op_a = 32'h0001_2345; op_b = 32'h0000_0100; rd_in = 5'd9; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         start = (i == 4);
         if (i == 4) begin funct3 = 3'd4; op_a = 32'd77; op_b = 32'd3; rd_in = 5'd17; end
         if (done) begin lat = i; break; end
         @(posedge clock); #1;
      end
      start = 1'b0;
      checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency got %0d expected 34", lat); end
      checks++; if (result !== exp) begin errors++; $display("FAIL ignore_result got %h expected %h", result, exp); end
      checks++; if (rd_out !== 5'd9) begin errors++; $display("FAIL ignore_rd_out got %0d expected 9", rd_out); end
      @(posedge clock); #1;
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, pulses;
      logic [31:0] res, pres, exp;
      logic [4:0] rdo;
      logic pd, pb;
      funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd12; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got %h expected 00000000", result); end
      checks++; if (rd_out !== 5'h0) begin errors++; $display("FAIL abort_rd_out got %0d expected 0", rd_out); end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) pulses++;
         @(posedge clock); #1;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_done_pulses got %0d expected 0", pulses); end
      exp = model(3'd4, 32'hFFFF_FC18, 32'd7);
      do_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd21, lat, bcnt, res, rdo, pd, pb, pres);
      checks++; if (res !== exp) begin errors++; $display("FAIL fresh_result got %h expected %h", res, exp); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL fresh_latency got %0d expected 34", lat); end
      checks++; if (rdo !== 5'd21) begin errors++; $display("FAIL fresh_rd_out got %0d expected 21", rdo); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
      #1;
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
